loopback_responder: RTL

Registered echo responder for the systolic test harnesses. It accepts words from a test initiator on a ready/valid input channel and buffers them in a small FIFO. Each word is returned, optionally bit-inverted, on a ready/valid output channel, so the initiator can check end-to-end integrity. It is the synthesizable counterpart to the harness-side stimulus/checker. It carries real flow control and latency in place of a combinational passthrough.

---
 rtl/loopback_responder_pkg.sv | 23 ++
 rtl/loopback_fifo.sv | 48 ++++
 rtl/loopback_responder.sv | 89 ++++++++
 3 files changed

// File: rtl/loopback_responder_pkg.sv
// rtl/loopback_responder_pkg.sv - shared helpers for the loopback responder
package loopback_responder_pkg;

    // Elaboration-time ceiling log2 used for pointer and counter widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Each returned bit after reset: memory is cleared, so the word is all-ones when inverting.
    function automatic logic reset_bit(input bit flip);
        return flip ? 1'b1 : 1'b0;
    endfunction

    function automatic logic flip_bit(input logic b, input bit flip);
        return flip ? ~b : b;
    endfunction

endpackage

// File: rtl/loopback_fifo.sv
// rtl/loopback_fifo.sv - word buffer with extra-MSB pointers for full/empty detection
module loopback_fifo
    import loopback_responder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  occupancy
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign occupancy = wr_ptr - rd_ptr;
    assign rd_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/loopback_responder.sv
// rtl/loopback_responder.sv - buffered echo responder with optional inversion and stall watchdog
module loopback_responder
    import loopback_responder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int FLIP  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_bits,
    output logic [clog2(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]       returned_cnt,
    output logic                   overrun
);

    localparam int SW = clog2(DEPTH + 1) + 1;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             stall;
    logic [WIDTH-1:0] rd_data;
    logic [SW-1:0]    stall_cnt;

    // Handshake readiness comes only from registered FIFO state.
    assign in_ready = !full;
    assign out_valid = !empty;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign stall = in_valid && !in_ready;

    loopback_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_data   (in_bits),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_comb begin
        out_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_bits[i] = flip_bit(rd_data[i], FLIP != 0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            returned_cnt <= '0;
        end else if (pop) begin
            returned_cnt <= returned_cnt + 1'b1;
        end
    end

    // Stall run saturates just past DEPTH; the cycle that pushes it beyond DEPTH latches overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (stall) begin
                if (stall_cnt != SW'(DEPTH + 1)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (stall_cnt >= SW'(DEPTH)) begin
                    overrun <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule
